// File: rtl/coin_entry.sv
`default_nettype none
// ============================================================================
// Module      : coin_entry
// Description : Deposit-key input conditioning for the coin accumulator.
//               Synchronizes KEY/SW, debounces the key and emits one
//               single-cycle event per clean press: a decoded coin value,
//               a coding error, or a drop while the accumulator is full.
//               Optional macro COIN_ENTRY_DEBOUNCE_EN enables the
//               DEBOUNCE_CYCLES stability counter; without it the debounce
//               states pass through in one cycle (fast simulation build).
// Revision    : 1.0 - initial release
// ============================================================================
module coin_entry #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       MAX10_CLK1_50,
  input  logic       reset,
  input  logic       key_n,
  input  logic [3:0] sw,
  input  logic       hold,
  output logic       coin_valid,
  output logic [6:0] coin_value,
  output logic       coin_err,
  output logic       coin_drop,
  output logic [7:0] coin_count,
  output logic       busy
);

  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    PRESS_DB   = 2'd1,
    PRESSED    = 2'd2,
    RELEASE_DB = 2'd3
  } db_state_t;

  db_state_t   r_state;
  db_state_t   w_state_next;
  logic        r_key_s1;
  logic        r_key_s2;
  logic [3:0]  r_sw_s1;
  logic [3:0]  r_sw_s2;
  logic        w_at_limit;
  logic        w_fire;
  logic        w_legal;
  logic [6:0]  w_value;

  // Two-flop synchronizers; the key idles high (released) out of reset.
  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      r_key_s1 <= 1'b1;
      r_key_s2 <= 1'b1;
      r_sw_s1  <= 4'b0000;
      r_sw_s2  <= 4'b0000;
    end else begin
      r_key_s1 <= key_n;
      r_key_s2 <= r_key_s1;
      r_sw_s1  <= sw;
      r_sw_s2  <= r_sw_s1;
    end
  end

`ifdef COIN_ENTRY_DEBOUNCE_EN
  localparam logic [19:0] c_DB_LIMIT = 20'(DEBOUNCE_CYCLES);

  logic [19:0] r_cnt;
  logic [19:0] w_cnt_next;

  assign w_at_limit = (r_cnt == c_DB_LIMIT);

  // Stability counter: starts at 1 on entry to a debounce state, restarts on
  // any bounce and is cleared once the window completes, so it never passes
  // the limit.
  always_comb begin
    w_cnt_next = 20'd0;
    case (r_state)
      RELEASED:   w_cnt_next = r_key_s2 ? 20'd0 : 20'd1;
      PRESS_DB:   w_cnt_next = (r_key_s2 || w_at_limit) ? 20'd0 : r_cnt + 20'd1;
      PRESSED:    w_cnt_next = r_key_s2 ? 20'd1 : 20'd0;
      RELEASE_DB: w_cnt_next = (!r_key_s2 || w_at_limit) ? 20'd0 : r_cnt + 20'd1;
      default:    w_cnt_next = 20'd0;
    endcase
  end

  // Stability counter register.
  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      r_cnt <= 20'd0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end
`else
  // Fast build: every debounce window is a single cycle. The parameter is
  // kept so both builds share one instantiation.
  logic w_unused_cfg;

  assign w_at_limit   = 1'b1;
  assign w_unused_cfg = ^DEBOUNCE_CYCLES;
`endif

  // Debounce state register.
  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      r_state <= RELEASED;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Debounce next-state; the press decision fires only on PRESS_DB->PRESSED.
  always_comb begin
    w_state_next = r_state;
    w_fire       = 1'b0;
    case (r_state)
      RELEASED: begin
        if (!r_key_s2) w_state_next = PRESS_DB;
      end
      PRESS_DB: begin
        if (r_key_s2) begin
          w_state_next = RELEASED;
        end else if (w_at_limit) begin
          w_state_next = PRESSED;
          w_fire       = 1'b1;
        end
      end
      PRESSED: begin
        if (r_key_s2) w_state_next = RELEASE_DB;
      end
      RELEASE_DB: begin
        if (!r_key_s2) begin
          w_state_next = PRESSED;
        end else if (w_at_limit) begin
          w_state_next = RELEASED;
        end
      end
      default: w_state_next = RELEASED;
    endcase
  end

  // One-hot (or all-zero) switch decode into cents.
  always_comb begin
    w_legal = 1'b1;
    w_value = 7'd0;
    case (r_sw_s2)
      4'b0000: w_value = 7'd0;
      4'b0001: w_value = 7'd1;
      4'b0010: w_value = 7'd5;
      4'b0100: w_value = 7'd10;
      4'b1000: w_value = 7'd25;
      default: w_legal = 1'b0;
    endcase
  end

  // Registered event pulses and saturating count of non-zero coins; a full
  // accumulator takes priority over decoding.
  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      coin_valid <= 1'b0;
      coin_value <= 7'd0;
      coin_err   <= 1'b0;
      coin_drop  <= 1'b0;
      coin_count <= 8'd0;
    end else begin
      coin_valid <= 1'b0;
      coin_value <= 7'd0;
      coin_err   <= 1'b0;
      coin_drop  <= 1'b0;
      if (w_fire) begin
        if (hold) begin
          coin_drop <= 1'b1;
        end else if (w_legal) begin
          coin_valid <= 1'b1;
          coin_value <= w_value;
          if ((w_value != 7'd0) && (coin_count != 8'hFF)) begin
            coin_count <= coin_count + 8'd1;
          end
        end else begin
          coin_err <= 1'b1;
        end
      end
    end
  end

  assign busy = (r_state != RELEASED);

endmodule
`default_nettype wire
